hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Issue-side pipeline controller that decides, each cycle, whether the instruction at decode may enter execute. It tracks in-flight GPR writes in a scoreboard shift register mirroring the execute-to-write-back layers. It raises `stall_pc` on read-after-write hazards and generates the post-branch `flush` window. It drives the `stall_pc` and `flush` signals consumed by the write-back phase and the fetch/decode stages.

## Interface
- `REG_N`, 32: number of architectural registers tracked, including RIP and EFLAGS slots.
- `REG_ADDR_W`, 5: register address width.
- `WB_DEPTH`, 3: cycles from issue acceptance to the GPR write edge, ≥1.
- `FLUSH_CYCLES`, 2: length of the flush window after a taken branch, ≥1.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `issue_valid` in 1: decode holds an instruction.
- `src_a_use`, `src_b_use` in 1 each: operand reads a GPR.
- `src_a_addr`, `src_b_addr` in REG_ADDR_W each: operand register.
- `dst_we` in 1: instruction writes a GPR.
- `dst_addr` in REG_ADDR_W: destination register.
- `branch_taken` in 1: execute resolved a taken branch this cycle.
- `issue_ready` out 1: instruction accepted this cycle.
- `stall_pc` out 1: hold PC and decode.
- `flush` out 1: squash fetch/decode contents.
- `busy_mask` out REG_N: bit r set if register r has a pending write.
- `stall_cnt` out 32: saturating count of stall cycles.
- `flush_cnt` out 32: saturating count of taken-branch flush events.

## Operation
- Scoreboard: `WB_DEPTH` entries of {valid, addr}; stage 0 is youngest. All stages shift every cycle regardless of stall. Stage 0 loads {accept & dst_we, dst_addr}. The entry leaving stage WB_DEPTH-1 is dropped.
- `busy_mask[r]` = OR over stages of (valid & addr==r), combinational.
- hazard = (src_a_use & busy_mask[src_a_addr]) | (src_b_use & busy_mask[src_b_addr]).
- The current instruction's own dst never creates a hazard against its own sources.
- An entry in stage WB_DEPTH-1 still counts as pending in that cycle, because the write lands at the cycle's closing edge.
- `stall_pc` = issue_valid & hazard & ~flush.
- `issue_ready` = issue_valid & ~hazard & ~flush.
- accept = issue_ready & ~branch_taken. An instruction presented in the same cycle as branch_taken is the wrong-path successor and is not entered.
- Flush timer:
  - branch_taken loads the counter with FLUSH_CYCLES.
  - `flush` = (counter≠0); the counter decrements while non-zero.
  - branch_taken while flushing reloads the counter to FLUSH_CYCLES. flush_cnt counts each branch_taken.
- Counters:
  - stall_cnt +1 on each cycle with stall_pc.
  - flush_cnt +1 on each branch_taken.
  - Both hold at 2^32-1.
- Reset: all scoreboard entries invalid, flush counter 0, stall_cnt = flush_cnt = 0. Consequently flush=0, busy_mask=0, stall_pc=0. issue_ready follows issue_valid.
- Reset mid-operation discards all pending entries and any active flush window on the next edge.

## Timing
- Hazard detection, `stall_pc` and `issue_ready` are combinational in the decode cycle, with zero latency.
- Issue of dst r accepted in cycle t makes r busy in cycles t+1 … t+WB_DEPTH. A dependent reader is accepted no earlier than cycle t+WB_DEPTH+1.
- branch_taken in cycle t gives flush=1 in cycles t+1 … t+FLUSH_CYCLES. issue_ready is 0 throughout that window.
- stall_cnt and flush_cnt update at the edge closing the counted cycle.

## Structure
- Shared package `hazard_pkg`: typedef `sb_entry_t` {logic valid; logic [REG_ADDR_W-1:0] addr}. Default constants WB_DEPTH and FLUSH_CYCLES live there, aligned with the write-back layer count and load latency.
- One sub-module: `flush_timer` (branch_taken in, flush out, reloadable down-counter, parameter FLUSH_CYCLES).

## Test plan
All scenarios use WB_DEPTH=3 and FLUSH_CYCLES=2.
- RAW stall: cycle 0 issue dst=3 we=1; cycle 1 on issue src_a=3.
  - stall_pc=1 in cycles 1–3, issue_ready=1 in cycle 4, stall_cnt=3.
  - busy_mask=0x8 in cycles 1–3, 0 in cycle 4.
- No false hazard: cycle 0 issue dst=3; cycle 1 issue src_a=4, src_b_use=0 with src_b_addr=3 → accepted in cycle 1, no stall.
- Taken branch:
  - branch_taken in cycle 5 with issue_valid=1 dst=7 → dst 7 never appears in busy_mask.
  - flush=1 in cycles 6–7, issue_ready=0 in cycles 6–7, flush_cnt=1.
- Branch reload: branch_taken in cycles 5 and 6 → flush=1 in cycles 6–8, flush_cnt=2.
- Reset mid-operation: busy_mask=0x8 and flush=1, then rstn=0 for one edge → next cycle busy_mask=0, flush=0, counters=0.
- Saturation: stall_cnt forced near max (via long stall run in a reduced-width build) → holds at all-ones.

Source files
------------

// File: rtl/hazard_scheduler_pkg.sv
// hazard_pkg: shared scoreboard entry type and default pipeline depths.
package hazard_pkg;
    localparam int REG_N = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DEF_WB_DEPTH = 3;
    localparam int DEF_FLUSH_CYCLES = 2;
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
    } sb_entry_t;
endpackage

// File: rtl/hazard_scheduler_if.sv
// hazard_scheduler_if: decode-side issue request and scheduler status bundle.
interface hazard_scheduler_if import hazard_pkg::*; #(parameter int CNT_W = 32);
    logic                  issue_valid, src_a_use, src_b_use, dst_we, branch_taken;
    logic [REG_ADDR_W-1:0] src_a_addr, src_b_addr, dst_addr;
    logic                  issue_ready, stall_pc, flush;
    logic [REG_N-1:0]      busy_mask;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;
    modport master(output issue_valid, src_a_use, src_b_use, src_a_addr, src_b_addr, dst_we, dst_addr, branch_taken,
                   input issue_ready, stall_pc, flush, busy_mask, stall_cnt, flush_cnt);
    modport slave(input issue_valid, src_a_use, src_b_use, src_a_addr, src_b_addr, dst_we, dst_addr, branch_taken,
                  output issue_ready, stall_pc, flush, busy_mask, stall_cnt, flush_cnt);
endinterface

// File: rtl/hazard_scheduler_flush_timer.sv
// flush_timer: reloadable down-counter; flush is high while the count is non-zero.
module flush_timer #(parameter int FLUSH_CYCLES = 2) (
    input  logic clk,
    input  logic rstn,
    input  logic branch_taken_i,
    output logic flush_o
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = branch_taken_i ? CW'(FLUSH_CYCLES) : cnt_q - CW'(cnt_q != '0);
    always_ff @(posedge clk) cnt_q <= !rstn ? '0 : cnt_d;
    assign flush_o = cnt_q != '0;
endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: RAW stall and post-branch flush control for the decode-to-execute boundary.
module hazard_scheduler import hazard_pkg::*; #(
    parameter int WB_DEPTH = DEF_WB_DEPTH,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rstn,
    hazard_scheduler_if.slave sched_if
);
    sb_entry_t [WB_DEPTH-1:0] sb_q, sb_d;
    logic [REG_N-1:0] busy;
    logic hazard, flush, stall, ready, accept;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    flush_timer #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush (
        .clk(clk), .rstn(rstn), .branch_taken_i(sched_if.branch_taken), .flush_o(flush));
    // The oldest stage still counts: its write lands at the closing edge of this cycle.
    always_comb begin
        busy = '0;
        for (int i = 0; i < WB_DEPTH; i++) if (sb_q[i].valid) busy[sb_q[i].addr] = 1'b1;
    end
    assign hazard = (sched_if.src_a_use & busy[sched_if.src_a_addr]) | (sched_if.src_b_use & busy[sched_if.src_b_addr]);
    assign stall  = sched_if.issue_valid & hazard & ~flush;
    assign ready  = sched_if.issue_valid & ~hazard & ~flush;
    assign accept = ready & ~sched_if.branch_taken;
    always_comb begin
        sb_d[0] = '{valid: accept & sched_if.dst_we, addr: sched_if.dst_addr};
        for (int i = 1; i < WB_DEPTH; i++) sb_d[i] = sb_q[i-1];
        stall_cnt_d = stall_cnt_q + CNT_W'(stall & ~&stall_cnt_q);
        flush_cnt_d = flush_cnt_q + CNT_W'(sched_if.branch_taken & ~&flush_cnt_q);
    end
    always_ff @(posedge clk) begin
        sb_q        <= !rstn ? '0 : sb_d;
        stall_cnt_q <= !rstn ? '0 : stall_cnt_d;
        flush_cnt_q <= !rstn ? '0 : flush_cnt_d;
    end
    assign sched_if.issue_ready = ready;
    assign sched_if.stall_pc    = stall;
    assign sched_if.flush       = flush;
    assign sched_if.busy_mask   = busy;
    assign sched_if.stall_cnt   = stall_cnt_q;
    assign sched_if.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed scenarios with a queue of expected per-cycle outputs.
module tb_hazard_scheduler;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    hazard_scheduler_if #(.CNT_W(32)) bus ();
    hazard_scheduler_if #(.CNT_W(4))  bus2 ();

    hazard_scheduler #(.WB_DEPTH(3), .FLUSH_CYCLES(2), .CNT_W(32)) dut (.clk(clk), .rstn(rstn), .sched_if(bus.slave));
    hazard_scheduler #(.WB_DEPTH(3), .FLUSH_CYCLES(2), .CNT_W(4))  dut2 (.clk(clk), .rstn(rstn), .sched_if(bus2.slave));

    typedef struct {
        string       tag;
        logic        ready;
        logic        stall;
        logic        flush;
        logic [31:0] busy;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(string tag, logic iv, logic au, logic [4:0] a, logic bu, logic [4:0] b,
                       logic we, logic [4:0] d, logic br, logic er, logic es, logic ef, logic [31:0] eb);
        exp_t e;
        bus.issue_valid = iv; bus.src_a_use = au; bus.src_a_addr = a; bus.src_b_use = bu; bus.src_b_addr = b;
        bus.dst_we = we; bus.dst_addr = d; bus.branch_taken = br;
        exp_q.push_back('{tag, er, es, ef, eb});
        @(negedge clk);
        e = exp_q.pop_front();
        chk({e.tag, ".ready"}, 32'(bus.issue_ready), 32'(e.ready));
        chk({e.tag, ".stall"}, 32'(bus.stall_pc), 32'(e.stall));
        chk({e.tag, ".flush"}, 32'(bus.flush), 32'(e.flush));
        chk({e.tag, ".busy"}, bus.busy_mask, e.busy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(string tag, logic ef, logic [31:0] eb);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ef, eb);
    endtask

    initial begin
        bus.issue_valid = 0; bus.src_a_use = 0; bus.src_b_use = 0; bus.src_a_addr = 0; bus.src_b_addr = 0;
        bus.dst_we = 0; bus.dst_addr = 0; bus.branch_taken = 0;
        bus2.issue_valid = 0; bus2.src_a_use = 0; bus2.src_b_use = 0; bus2.src_a_addr = 0; bus2.src_b_addr = 0;
        bus2.dst_we = 0; bus2.dst_addr = 0; bus2.branch_taken = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        // reset state; ready follows issue_valid
        cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("reset.stall_cnt", bus.stall_cnt, 0);
        chk("reset.flush_cnt", bus.flush_cnt, 0);
        // RAW on src_a
        cyc("raw.c0", 1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 32'h0);
        cyc("raw.c1", 1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8);
        cyc("raw.c2", 1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8);
        cyc("raw.c3", 1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8);
        cyc("raw.c4", 1, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        chk("raw.stall_cnt", bus.stall_cnt, 3);
        // RAW on src_b
        cyc("rawb.c0", 1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 32'h0);
        cyc("rawb.c1", 1, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0, 32'h20);
        cyc("rawb.c2", 1, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0, 32'h20);
        cyc("rawb.c3", 1, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0, 32'h20);
        cyc("rawb.c4", 1, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0, 32'h0);
        chk("rawb.stall_cnt", bus.stall_cnt, 6);
        // unused src_b pointing at a busy register
        cyc("nofalse.c0", 1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 32'h0);
        cyc("nofalse.c1", 1, 1, 4, 0, 3, 0, 0, 0, 1, 0, 0, 32'h8);
        idle("nofalse.c2", 0, 32'h8);
        idle("nofalse.c3", 0, 32'h8);
        idle("nofalse.c4", 0, 32'h0);
        chk("nofalse.stall_cnt", bus.stall_cnt, 6);
        // taken branch: same-cycle dst 7 is wrong-path and must not enter
        cyc("br.c0", 1, 0, 0, 0, 0, 1, 7, 1, 1, 0, 0, 32'h0);
        cyc("br.c1", 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 32'h0);
        cyc("br.c2", 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 32'h0);
        idle("br.c3", 0, 32'h0);
        idle("br.c4", 0, 32'h0);
        chk("br.flush_cnt", bus.flush_cnt, 1);
        // back-to-back branches reload the window
        cyc("reload.c0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        cyc("reload.c1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
        idle("reload.c2", 1, 32'h0);
        idle("reload.c3", 1, 32'h0);
        idle("reload.c4", 0, 32'h0);
        chk("reload.flush_cnt", bus.flush_cnt, 3);
        // reset mid-operation with a pending write and an active flush
        cyc("rst.c0", 1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 32'h0);
        cyc("rst.c1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h8);
        rstn = 1'b0;
        idle("rst.c2", 1, 32'h8);
        rstn = 1'b1;
        idle("rst.c3", 0, 32'h0);
        chk("rst.stall_cnt", bus.stall_cnt, 0);
        chk("rst.flush_cnt", bus.flush_cnt, 0);
        // saturation on a 4-bit counter build: a self-dependent writer stalls 3 of every 4 cycles
        bus2.issue_valid = 1; bus2.src_a_use = 1; bus2.src_a_addr = 1; bus2.dst_we = 1; bus2.dst_addr = 1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("sat.stall_cnt", 32'(bus2.stall_cnt), 32'hF);
        @(posedge clk);
        #1 bus2.issue_valid = 0; bus2.branch_taken = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat.flush_cnt", 32'(bus2.flush_cnt), 32'hF);
        chk("sat.stall_hold", 32'(bus2.stall_cnt), 32'hF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
